// File: rtl/seq_arith_core_pkg.sv
// Shared constants for the sequential multiply/divide core:
// FSM state encodings and operation-mode values.
package seq_arith_core_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_CALC = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    localparam logic MODE_DIV = 1'b0;
    localparam logic MODE_MUL = 1'b1;

endpackage

// File: rtl/seq_arith_core_start_edge_det.sv
// Start-request conditioner. With START_EDGE = 1 it emits a one-cycle
// trig on each rising edge of start; with START_EDGE = 0 start passes
// straight through as a level. The history register always tracks start,
// so a level held across an operation never produces a second edge.
module start_edge_det #(
    parameter bit START_EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic trig
);

    logic start_prev;

    // Remember last sampled start level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
        end else begin
            start_prev <= start;
        end
    end

    assign trig = START_EDGE ? (start & ~start_prev) : start;

endmodule

// File: rtl/seq_arith_core.sv
// Sequential unsigned multiply / restoring divide core sharing one
// accumulator, one shift register and one iteration counter.
// Handshake: a trigger sampled in IDLE captures a, b and mode; busy stays
// high through CALC and DONE; done pulses for one cycle as result and
// div_zero update, and result then holds until the next done.
module seq_arith_core
    import seq_arith_core_pkg::*;
#(
    parameter int W          = 4,
    parameter bit START_EDGE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           busy,
    output logic           done,
    output logic           div_zero,
    output logic [1:0]     fsm_state
);

    localparam int CW = $clog2(W + 1);

    logic [1:0]   state;
    logic         trig;
    logic [CW-1:0] cnt;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic         mode_r;
    logic [W:0]   acc;   // remainder (divide) / upper product half (multiply)
    logic [W-1:0] sh;    // dividend->quotient (divide) / multiplier->low product (multiply)

    logic [W:0]   trial;
    logic         div_ge;
    logic [W:0]   div_acc;
    logic [W-1:0] div_sh;
    logic [W:0]   mul_sum;
    logic [W:0]   mul_acc;
    logic [W-1:0] mul_sh;
    logic         zero_div;

    start_edge_det #(
        .START_EDGE (START_EDGE)
    ) u_start_edge_det (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .trig  (trig)
    );

    // One iteration of each algorithm, computed from the current registers.
    always_comb begin
        trial   = {acc[W-1:0], sh[W-1]};
        div_ge  = (trial >= {1'b0, b_r});
        div_acc = div_ge ? (trial - {1'b0, b_r}) : trial;
        div_sh  = {sh[W-2:0], div_ge};
        // acc[W] is always 0 between multiply iterations, so the sum fits W+1 bits.
        mul_sum = acc + (sh[0] ? {1'b0, a_r} : {(W+1){1'b0}});
        mul_acc = {1'b0, mul_sum[W:1]};
        mul_sh  = {mul_sum[0], sh[W-1:1]};
        zero_div = (mode_r == MODE_DIV) && (b_r == '0);
    end

    // Control FSM, operand capture, iteration and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STATE_IDLE;
            cnt      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            mode_r   <= MODE_DIV;
            acc      <= '0;
            sh       <= '0;
            result   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (trig) begin
                        a_r    <= a;
                        b_r    <= b;
                        mode_r <= mode;
                        acc    <= '0;
                        sh     <= (mode == MODE_MUL) ? b : a;
                        cnt    <= CW'(W);
                        // A zero divisor has a fixed answer; skip the iterations.
                        if ((mode == MODE_DIV) && (b == '0)) begin
                            state <= STATE_DONE;
                        end else begin
                            state <= STATE_CALC;
                        end
                    end
                end
                STATE_CALC: begin
                    if (mode_r == MODE_MUL) begin
                        acc <= mul_acc;
                        sh  <= mul_sh;
                    end else begin
                        acc <= div_acc;
                        sh  <= div_sh;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    done     <= 1'b1;
                    div_zero <= zero_div;
                    if (zero_div) begin
                        result <= {a_r, {W{1'b1}}};
                    end else begin
                        result <= {acc[W-1:0], sh};
                    end
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != STATE_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_seq_arith_core.sv
// Directed bench for seq_arith_core: a W=4 and a W=8 instance, both with
// rising-edge start, sharing clock and reset.
module tb_seq_arith_core;

    localparam logic DIV = 1'b0;
    localparam logic MUL = 1'b1;

    logic       clk;
    logic       rst;

    logic       start4, mode4;
    logic [3:0] a4, b4;
    logic [7:0] result4;
    logic       busy4, done4, dz4;
    logic [1:0] st4;

    logic       start8, mode8;
    logic [7:0] a8, b8;
    logic [15:0] result8;
    logic       busy8, done8, dz8;
    logic [1:0] st8;

    int n_checks = 0;
    int n_pass   = 0;

    seq_arith_core #(.W(4), .START_EDGE(1'b1)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .result(result4), .busy(busy4), .done(done4), .div_zero(dz4),
        .fsm_state(st4)
    );

    seq_arith_core #(.W(8), .START_EDGE(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .result(result8), .busy(busy8), .done(done8), .div_zero(dz8),
        .fsm_state(st8)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done4(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done4 && cyc < 40);
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done8 && cyc < 40);
    endtask

    // Start pulse, then scramble inputs to show they are not re-read.
    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic md,
                        input string tag, output int cyc);
        a4 = av; b4 = bv; mode4 = md; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check({tag, "_busy"}, busy4, 1);
        a4 = ~av; b4 = ~bv; mode4 = ~md;
        wait_done4(cyc);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic md,
                        input string tag, output int cyc);
        a8 = av; b8 = bv; mode8 = md; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check({tag, "_busy"}, busy8, 1);
        a8 = ~av; b8 = ~bv; mode8 = ~md;
        wait_done8(cyc);
    endtask

    initial begin
        int cyc;
        int ndone;
        int first;

        rst = 1'b1;
        start4 = 0; mode4 = 0; a4 = 0; b4 = 0;
        start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_result4", result4, 0);
        check("rst_busy4",   busy4,   0);
        check("rst_done4",   done4,   0);
        check("rst_dz4",     dz4,     0);
        check("rst_state4",  st4,     0);
        check("rst_result8", result8, 0);
        check("rst_state8",  st8,     0);

        // 13 / 3 -> q=4 r=1
        run4(4'd13, 4'd3, DIV, "div13_3", cyc);
        check("div13_3_lat", cyc, 5);
        check("div13_3_res", result4, 8'h14);
        check("div13_3_dz",  dz4, 0);
        @(posedge clk); #1;
        check("div13_3_done_width", done4, 0);
        check("div13_3_idle_busy",  busy4, 0);
        check("div13_3_hold",       result4, 8'h14);

        // 15 * 15 = 225
        run4(4'd15, 4'd15, MUL, "mul15_15", cyc);
        check("mul15_15_lat", cyc, 5);
        check("mul15_15_res", result4, 8'hE1);
        check("mul15_15_dz",  dz4, 0);

        // 9 / 0 -> q=F r=9, flagged
        run4(4'd9, 4'd0, DIV, "div9_0", cyc);
        check("div9_0_lat", cyc, 1);
        check("div9_0_res", result4, 8'h9F);
        check("div9_0_dz",  dz4, 1);
        @(posedge clk); #1;
        check("div9_0_dz_hold", dz4, 1);

        // 3 * 5 = 15, clears the flag
        run4(4'd3, 4'd5, MUL, "mul3_5", cyc);
        check("mul3_5_lat", cyc, 5);
        check("mul3_5_res", result4, 8'h0F);
        check("mul3_5_dz",  dz4, 0);

        // start held high for 30 cycles: one operation only (7*6=42)
        a4 = 4'd7; b4 = 4'd6; mode4 = MUL; start4 = 1'b1;
        ndone = 0; first = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        check("held_ndone", ndone, 1);
        check("held_lat",   first, 6);
        check("held_res",   result4, 8'h2A);
        start4 = 1'b0;
        @(posedge clk); #1;
        // re-assert: 14 / 5 -> q=2 r=4
        run4(4'd14, 4'd5, DIV, "rearm", cyc);
        check("rearm_lat", cyc, 5);
        check("rearm_res", result4, 8'h42);

        // reset two cycles into CALC
        a4 = 4'd13; b4 = 4'd3; mode4 = DIV; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", busy4, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_result", result4, 0);
        check("abort_busy",   busy4,   0);
        check("abort_done",   done4,   0);
        check("abort_dz",     dz4,     0);
        check("abort_state",  st4,     0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done4) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run4(4'd12, 4'd4, DIV, "div12_4", cyc);
        check("div12_4_lat", cyc, 5);
        check("div12_4_res", result4, 8'h03);

        // W=8: 200 / 7 -> q=28 r=4, with a start while busy
        a8 = 8'd200; b8 = 8'd7; mode8 = DIV; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        ndone = 0; first = 0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin
                start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
            end
            if (i == 3) start8 = 1'b0;
            if (done8) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        check("w8_div_ndone", ndone, 1);
        check("w8_div_lat",   first, 9);
        check("w8_div_res",   result8, 16'h041C);
        check("w8_div_dz",    dz8, 0);

        // W=8: 255 * 255 = 65025
        run8(8'd255, 8'd255, MUL, "w8_mul", cyc);
        check("w8_mul_lat", cyc, 9);
        check("w8_mul_res", result8, 16'hFE01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_arith_core.md
SEQ_ARITH_CORE -- requirements
Module: seq_arith_core

Interface
REQ-001 Parameter W SHALL default to 4 and set the operand width; the legal range is 2..16.
REQ-002 Parameter START_EDGE SHALL default to 1. When 1, a start is triggered by a rising edge of start. When 0, start is treated as a level.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Port start  in  1  SHALL be the operation request, e.g. a button-derived level.
REQ-006 Port mode  in  1  SHALL select the operation: 0 = divide, 1 = multiply.
REQ-007 Port a  in  W  SHALL carry the dividend or multiplicand.
REQ-008 Port b  in  W  SHALL carry the divisor or multiplier.
REQ-009 Port result  out  2W  SHALL carry the output. For divide: {remainder, quotient}, with quotient in [W-1:0]. For multiply: the product.
REQ-010 Port busy  out  1  SHALL be high while an operation is in progress.
REQ-011 Port done  out  1  SHALL be a one-cycle pulse marking completion.
REQ-012 Port div_zero  out  1  SHALL flag that the last divide had b = 0; it holds until the next done.

Function
REQ-013 The FSM states SHALL be IDLE, CALC and DONE.
REQ-014 In IDLE, a start trigger (a rising edge of start, or start high when START_EDGE = 0) SHALL capture a, b and mode into internal registers at that clock edge.
  - Normal case: go to CALC with the iteration counter set to W.
REQ-015 A divide with captured b = 0 SHALL skip CALC and go directly to DONE.
REQ-016 Each CALC cycle SHALL perform exactly one iteration:
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - The counter decrements each cycle; CALC goes to DONE when the counter reaches 0 after the W-th iteration.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, result and div_zero SHALL update, and the FSM SHALL return to IDLE on the next cycle.
REQ-018 Latency: done SHALL assert W+1 cycles after the capturing edge for a normal operation, and 1 cycle after it for a divide by zero.
REQ-019 For a divide by zero, result SHALL be quotient = all ones and remainder = a, with div_zero = 1.
REQ-020 busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-021 result SHALL hold its value between done pulses; partial values SHALL never appear on result.
REQ-022 start triggers that arrive while busy SHALL be ignored and not queued.
  - The edge detector SHALL keep tracking start throughout, so a start held across completion does not retrigger.
REQ-023 A start trigger in the same cycle that DONE returns to IDLE SHALL be ignored; only triggers sampled in IDLE count.
REQ-024 Changes on a, b or mode after capture SHALL NOT affect the operation in progress.
REQ-025 All arithmetic SHALL be unsigned.
  - The divide remainder register is W+1 bits for the subtract compare.
  - The product is exactly 2W bits with no overflow possible.

Reset
REQ-026 When rst = 1 at a clock edge, the block SHALL enter IDLE and clear:
  - result = 0, done = 0, busy = 0, div_zero = 0;
  - the iteration counter and operand registers = 0;
  - the edge-detect register = 0.
REQ-027 rst asserted mid-CALC SHALL abort the operation with no done pulse; the first trigger after rst deasserts starts a fresh operation.
REQ-028 rst SHALL take priority over a start trigger in the same cycle.

Structure
REQ-029 A shared package/header SHALL hold the FSM state encodings (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2) and the mode constants (MODE_DIV = 0, MODE_MUL = 1).
REQ-030 The start edge detector SHALL be a separate sub-module, start_edge_det.
  - Inputs: clk, rst, start.
  - Output: one-cycle trig.
  - Behaviour: bypassed when START_EDGE = 0.
REQ-031 The datapath SHALL be shared between the two modes: one accumulator, one shift register and one counter of width clog2(W+1).

Verification
REQ-032 The bench SHALL cover at least these directed scenarios:
  - W = 4, divide, a = 13, b = 3, start pulse -> done 5 cycles after capture, result = {4'd1, 4'd4}, div_zero = 0.
  - W = 4, multiply, a = 15, b = 15 -> result = 8'd225, done after 5 cycles.
  - W = 4, divide, a = 9, b = 0 -> done 1 cycle after capture, result = {4'd9, 4'hF}, div_zero = 1.
  - START_EDGE = 1, start held high for 30 cycles -> exactly one done pulse; releasing and re-asserting start -> a second operation.
  - rst asserted 2 cycles into CALC -> no done, all outputs 0; a new start, divide 12/4 -> result = {4'd0, 4'd3}.
  - W = 8, divide 200/7 -> quotient 28, remainder 4, done after 9 cycles; start during busy -> ignored.
